// File: rtl/id_decode_stage_pkg.sv
// Shared types for the RV32I decode stage: ALU operation encodings, RV32I
//   opcode/funct constants, operand-A select, immediate formats and the
//   registered decode bundle. No ports; imported by rtl/ and tb/ files.

package ALU_OP;
  // SLT/SLTU sit after SRA so the older encodings keep their values.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;
endpackage

package RV32I_OPC;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    A_RS1  = 2'd0,
    A_PC   = 2'd1,
    A_ZERO = 2'd2
  } a_sel_e;
endpackage

package id_decode_stage_pkg;
  import ALU_OP::*;
  import RV32I_OPC::*;

  typedef enum logic [2:0] {
    FMT_NONE, FMT_I, FMT_SHAMT, FMT_S, FMT_B, FMT_U, FMT_J
  } imm_fmt_e;

  typedef struct packed {
    logic [31:0] pc;
    alu_op_e     alu_op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    a_sel_e      a_sel;
    logic        b_imm;
    logic [2:0]  funct3;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
    logic        branch;
    logic        jump;
    logic        illegal;
  } bundle_t;

  // Base ALU operation selected by funct3 alone (funct7 alternates handled by caller).
  function automatic alu_op_e f3_alu_op(input logic [2:0] f3);
    alu_op_e op;
    case (f3)
      F3_ADD_SUB: op = ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_SLT:     op = ALU_SLT;
      F3_SLTU:    op = ALU_SLTU;
      F3_XOR:     op = ALU_XOR;
      F3_SR:      op = ALU_SRL;
      F3_OR:      op = ALU_OR;
      default:    op = ALU_AND;
    endcase
    return op;
  endfunction
endpackage

// File: rtl/id_decode_stage_imm_gen.sv
// rv32i_imm_gen: combinational RV32I immediate extractor, sign-extended to 32 bits.
//   Ports: instr (in, 32) -> imm (out, 32), fmt (out, which encoding was used).
//   Zero latency, no state; unrecognised opcodes give imm=0, fmt=FMT_NONE.

module rv32i_imm_gen
  import RV32I_OPC::*;
  import id_decode_stage_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm,
  output imm_fmt_e    fmt
);

  always_comb begin
    imm = '0;
    fmt = FMT_NONE;
    case (instr[6:0])
      OPC_OP_IMM: begin
        // Shift-immediates carry a zero-extended shamt rather than an I immediate.
        if (instr[14:12] == F3_SLL || instr[14:12] == F3_SR) begin
          imm = {27'b0, instr[24:20]};
          fmt = FMT_SHAMT;
        end else begin
          imm = {{20{instr[31]}}, instr[31:20]};
          fmt = FMT_I;
        end
      end
      OPC_LOAD, OPC_JALR: begin
        imm = {{20{instr[31]}}, instr[31:20]};
        fmt = FMT_I;
      end
      OPC_STORE: begin
        imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        fmt = FMT_S;
      end
      OPC_BRANCH: begin
        imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        fmt = FMT_B;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm = {instr[31:12], 12'b0};
        fmt = FMT_U;
      end
      OPC_JAL: begin
        imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        fmt = FMT_J;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_decode_stage.sv
// id_decode_stage: RV32I decoder feeding one output pipeline register for execute.
//   Latency 1 cycle; in_ready = !out_valid || out_ready; flush kills held and incoming.
//   Ports: clk/rst (sync, active-high), in_valid/in_ready/in_instr/in_pc from fetch,
//   flush, out_valid/out_ready and the registered decoded bundle out_* to execute.

module id_decode_stage
  import ALU_OP::*;
  import RV32I_OPC::*;
  import id_decode_stage_pkg::*;
#(
  parameter int XLEN         = 32,  // only 32 is supported
  parameter bit RD0_SUPPRESS = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [3:0]      out_alu_op,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [1:0]      out_a_sel,
  output logic            out_b_imm,
  output logic [2:0]      out_funct3,
  output logic            out_reg_we,
  output logic            out_mem_re,
  output logic            out_mem_we,
  output logic            out_branch,
  output logic            out_jump,
  output logic            out_illegal
);

  logic [31:0] imm;
  imm_fmt_e    imm_fmt;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        illegal;
  logic        load;
  bundle_t     dec;
  bundle_t     bundle_d, bundle_q;
  logic        valid_d, valid_q;

  rv32i_imm_gen u_imm_gen (
    .instr (in_instr),
    .imm   (imm),
    .fmt   (imm_fmt)
  );

  assign f3 = in_instr[14:12];
  assign f7 = in_instr[31:25];

  always_comb begin
    dec        = '0;
    illegal    = 1'b0;
    dec.pc     = in_pc;
    dec.rs1    = in_instr[19:15];
    dec.rs2    = in_instr[24:20];
    dec.rd     = in_instr[11:7];
    dec.funct3 = f3;
    dec.imm    = imm;
    dec.alu_op = ALU_ADD;
    dec.a_sel  = A_RS1;
    // Every format with an immediate except B feeds it to ALU operand B;
    // branches compare rs1 against rs2.
    dec.b_imm  = (imm_fmt != FMT_NONE) && (imm_fmt != FMT_B);

    case (in_instr[6:0])
      OPC_OP: begin
        dec.reg_we = 1'b1;
        dec.alu_op = f3_alu_op(f3);
        if (f7 == F7_ALT && f3 == F3_ADD_SUB)  dec.alu_op = ALU_SUB;
        else if (f7 == F7_ALT && f3 == F3_SR)  dec.alu_op = ALU_SRA;
        else if (f7 != F7_BASE)                illegal    = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.reg_we = 1'b1;
        dec.alu_op = f3_alu_op(f3);
        if (f3 == F3_SLL) begin
          illegal = (f7 != F7_BASE);
        end else if (f3 == F3_SR) begin
          if (f7 == F7_ALT)       dec.alu_op = ALU_SRA;
          else if (f7 != F7_BASE) illegal    = 1'b1;
        end
      end
      OPC_LUI: begin
        dec.reg_we = 1'b1;
        dec.a_sel  = A_ZERO;
      end
      OPC_AUIPC: begin
        dec.reg_we = 1'b1;
        dec.a_sel  = A_PC;
      end
      OPC_LOAD: begin
        dec.reg_we = 1'b1;
        dec.mem_re = 1'b1;
      end
      OPC_STORE: dec.mem_we = 1'b1;
      OPC_BRANCH: begin
        dec.alu_op = ALU_SUB;
        dec.branch = 1'b1;
      end
      OPC_JAL: begin
        dec.reg_we = 1'b1;
        dec.jump   = 1'b1;
        dec.a_sel  = A_PC;
      end
      OPC_JALR: begin
        dec.reg_we = 1'b1;
        dec.jump   = 1'b1;
      end
      OPC_FENCE: ;  // executes as a NOP in this core
      default: illegal = 1'b1;  // includes any word whose low bits are not 11
    endcase

    // Illegal words reach execute as an inert bundle with only the trap flag set;
    // register fields, funct3 and PC stay visible for the trap handler.
    if (illegal) begin
      dec.alu_op  = ALU_ADD;
      dec.a_sel   = A_RS1;
      dec.b_imm   = 1'b0;
      dec.imm     = '0;
      dec.reg_we  = 1'b0;
      dec.mem_re  = 1'b0;
      dec.mem_we  = 1'b0;
      dec.branch  = 1'b0;
      dec.jump    = 1'b0;
      dec.illegal = 1'b1;
    end

    if (RD0_SUPPRESS && dec.rd == 5'd0) dec.reg_we = 1'b0;
  end

  assign in_ready = !valid_q || out_ready;
  assign load     = in_valid && in_ready && !flush;

  always_comb begin
    valid_d  = valid_q;
    bundle_d = bundle_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d  = 1'b1;
      bundle_d = dec;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
    end else begin
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_pc      = bundle_q.pc;
  assign out_alu_op  = bundle_q.alu_op;
  assign out_rs1     = bundle_q.rs1;
  assign out_rs2     = bundle_q.rs2;
  assign out_rd      = bundle_q.rd;
  assign out_imm     = bundle_q.imm;
  assign out_a_sel   = bundle_q.a_sel;
  assign out_b_imm   = bundle_q.b_imm;
  assign out_funct3  = bundle_q.funct3;
  assign out_reg_we  = bundle_q.reg_we;
  assign out_mem_re  = bundle_q.mem_re;
  assign out_mem_we  = bundle_q.mem_we;
  assign out_branch  = bundle_q.branch;
  assign out_jump    = bundle_q.jump;
  assign out_illegal = bundle_q.illegal;

endmodule

// File: tb/tb_id_decode_stage.sv
// Testbench for id_decode_stage: directed test-plan cases plus randomized decode
//   and handshake traffic against a behavioural model and a transaction queue.
//   Inputs driven 1 time unit after the rising edge; outputs sampled there too.

module tb_id_decode_stage;
  import ALU_OP::*;

  typedef logic [94:0] bun_t;

  localparam logic [31:0] I_ADD      = 32'h002081B3;
  localparam logic [31:0] I_SUB      = 32'h402081B3;
  localparam logic [31:0] I_SRAI     = 32'h40335293;
  localparam logic [31:0] I_SRAI_BAD = 32'h42335293;
  localparam logic [31:0] I_SW       = 32'hFE20AE23;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [3:0]  out_alu_op;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [31:0] out_imm;
  logic [1:0]  out_a_sel;
  logic        out_b_imm;
  logic [2:0]  out_funct3;
  logic        out_reg_we, out_mem_re, out_mem_we, out_branch, out_jump, out_illegal;

  int errors = 0;
  int checks = 0;

  id_decode_stage #(.XLEN(32), .RD0_SUPPRESS(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_alu_op(out_alu_op),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_imm(out_imm), .out_a_sel(out_a_sel), .out_b_imm(out_b_imm),
    .out_funct3(out_funct3),
    .out_reg_we(out_reg_we), .out_mem_re(out_mem_re), .out_mem_we(out_mem_we),
    .out_branch(out_branch), .out_jump(out_jump), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  function automatic bun_t observe();
    return {out_pc, out_alu_op, out_rs1, out_rs2, out_rd, out_imm, out_a_sel, out_b_imm,
            out_funct3, out_reg_we, out_mem_re, out_mem_we, out_branch, out_jump, out_illegal};
  endfunction

  // Reference decode, written from the ISA rules with plain arithmetic.
  function automatic bun_t model(input logic [31:0] ins, input logic [31:0] pc);
    logic [3:0]  f3_map [8];
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [3:0]  op;
    logic [1:0]  asel;
    logic        bimm, we, re, mw, br, jp, ill;
    logic [31:0] imm, i_imm, s_imm, b_imm, j_imm;
    f3_map = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    opc = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    op = ALU_ADD; asel = 2'd0; bimm = 1'b0; imm = '0;
    we = 1'b0; re = 1'b0; mw = 1'b0; br = 1'b0; jp = 1'b0; ill = 1'b0;
    i_imm = $signed(ins) >>> 20;
    s_imm = (i_imm & ~32'h1F) | {27'b0, ins[11:7]};
    b_imm = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
            + int'(ins[11:8]) * 2;
    j_imm = (ins[31] ? -1048576 : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
            + int'(ins[30:21]) * 2;
    if (ins[1:0] != 2'b11) ill = 1'b1;
    else begin
      case (opc)
        7'h33: begin
          we  = 1'b1;
          ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
          op  = (f7 == 7'h20) ? ((f3 == 3'd0) ? ALU_SUB : ALU_SRA) : f3_map[f3];
        end
        7'h13: begin
          we = 1'b1; bimm = 1'b1;
          if (f3 == 3'd1 || f3 == 3'd5) begin
            imm = {27'b0, ins[24:20]};
            ill = !(f7 == 7'h00 || (f3 == 3'd5 && f7 == 7'h20));
            op  = (f3 == 3'd5 && f7 == 7'h20) ? ALU_SRA : f3_map[f3];
          end else begin
            imm = i_imm;
            op  = f3_map[f3];
          end
        end
        7'h37: begin we = 1'b1; asel = 2'd2; bimm = 1'b1; imm = ins & 32'hFFFFF000; end
        7'h17: begin we = 1'b1; asel = 2'd1; bimm = 1'b1; imm = ins & 32'hFFFFF000; end
        7'h03: begin we = 1'b1; re = 1'b1; bimm = 1'b1; imm = i_imm; end
        7'h23: begin mw = 1'b1; bimm = 1'b1; imm = s_imm; end
        7'h63: begin br = 1'b1; op = ALU_SUB; imm = b_imm; end
        7'h6F: begin jp = 1'b1; we = 1'b1; asel = 2'd1; bimm = 1'b1; imm = j_imm; end
        7'h67: begin jp = 1'b1; we = 1'b1; bimm = 1'b1; imm = i_imm; end
        7'h0F: ;
        default: ill = 1'b1;
      endcase
    end
    if (ill) begin
      op = ALU_ADD; asel = 2'd0; bimm = 1'b0; imm = '0;
      we = 1'b0; re = 1'b0; mw = 1'b0; br = 1'b0; jp = 1'b0;
    end
    if (ins[11:7] == 5'd0) we = 1'b0;
    return {pc, op, ins[19:15], ins[24:20], ins[11:7], imm, asel, bimm, f3,
            we, re, mw, br, jp, ill};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  opcs [10];
    logic [31:0] r;
    int          k;
    opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h0F};
    r = $urandom();
    k = $urandom_range(0, 11);
    if (k >= 10) return r;
    r[6:0] = opcs[k];
    if ($urandom_range(0, 2) == 0)      r[31:25] = 7'h00;
    else if ($urandom_range(0, 1) == 0) r[31:25] = 7'h20;
    return r;
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic f, input logic ordy);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    flush     = f;
    out_ready = ordy;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    cyc(); cyc();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++;
    if (observe() !== '0) begin errors++; $display("FAIL reset_bundle got %h exp 0", observe()); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_add();
    logic [31:0] pc;
    pc = $urandom() & 32'hFFFF_FFFC;
    drive(1'b1, I_ADD, pc, 1'b0, 1'b1);
    cyc();
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %b exp 1", out_valid); end
    checks++;
    if ({out_alu_op, out_rs1, out_rs2, out_rd, out_b_imm, out_reg_we} !==
        {ALU_ADD, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL add_fields got op=%0d rs1=%0d rs2=%0d rd=%0d bimm=%b we=%b exp 0/1/2/3/0/1",
               out_alu_op, out_rs1, out_rs2, out_rd, out_b_imm, out_reg_we);
    end
    checks++;
    if (observe() !== model(I_ADD, pc)) begin
      errors++; $display("FAIL add_bundle got %h exp %h", observe(), model(I_ADD, pc));
    end
    cyc();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %b exp 0", out_valid); end
    checks++;
    if (observe() !== model(I_ADD, pc)) begin
      errors++; $display("FAIL drain_hold got %h exp %h", observe(), model(I_ADD, pc));
    end
  endtask

  task automatic test_srai();
    drive(1'b1, I_SRAI, 32'h100, 1'b0, 1'b1);
    cyc();
    drive(1'b1, I_SRAI_BAD, 32'h104, 1'b0, 1'b1);
    checks++;
    if ({out_valid, out_alu_op, out_imm, out_b_imm, out_rd} !==
        {1'b1, ALU_SRA, 32'h3, 1'b1, 5'd5}) begin
      errors++;
      $display("FAIL srai got v=%b op=%0d imm=%h bimm=%b rd=%0d exp 1/7/3/1/5",
               out_valid, out_alu_op, out_imm, out_b_imm, out_rd);
    end
    cyc();
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    checks++;
    if ({out_valid, out_illegal, out_reg_we} !== 3'b110) begin
      errors++;
      $display("FAIL srai_bad got v=%b ill=%b we=%b exp 1/1/0", out_valid, out_illegal, out_reg_we);
    end
    checks++;
    if (observe() !== model(I_SRAI_BAD, 32'h104)) begin
      errors++; $display("FAIL srai_bad_bundle got %h exp %h", observe(), model(I_SRAI_BAD, 32'h104));
    end
    cyc();
  endtask

  task automatic test_store();
    drive(1'b1, I_SW, 32'h200, 1'b0, 1'b1);
    cyc();
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    checks++;
    if ({out_alu_op, out_imm, out_mem_we, out_reg_we} !== {ALU_ADD, 32'hFFFF_FFFC, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL sw got op=%0d imm=%h mw=%b we=%b exp 0/fffffffc/1/0",
               out_alu_op, out_imm, out_mem_we, out_reg_we);
    end
    cyc();
  endtask

  task automatic test_back_pressure();
    drive(1'b1, I_ADD, 32'h300, 1'b0, 1'b1);
    cyc();
    drive(1'b1, I_SUB, 32'h304, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d] got %b exp 0", i, in_ready); end
      cyc();
      checks++;
      if (out_valid !== 1'b1 || observe() !== model(I_ADD, 32'h300)) begin
        errors++;
        $display("FAIL stall_hold[%0d] got v=%b %h exp v=1 %h", i, out_valid, observe(),
                 model(I_ADD, 32'h300));
      end
    end
    drive(1'b1, I_SUB, 32'h304, 1'b0, 1'b1);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b exp 1", in_ready); end
    cyc();
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || observe() !== model(I_SUB, 32'h304)) begin
      errors++;
      $display("FAIL release_sub got v=%b %h exp v=1 %h", out_valid, observe(), model(I_SUB, 32'h304));
    end
    cyc();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL no_dup got %b exp 0", out_valid); end
  endtask

  task automatic test_flush();
    drive(1'b1, I_ADD, 32'h400, 1'b1, 1'b1);
    cyc();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_accept got %b exp 0", out_valid); end
    drive(1'b1, I_ADD, 32'h404, 1'b0, 1'b1);
    cyc();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_setup got %b exp 1", out_valid); end
    cyc();
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_held got %b exp 0", out_valid); end
    cyc();
  endtask

  task automatic test_illegal_and_reset();
    drive(1'b1, 32'h0, 32'h500, 1'b0, 1'b1);
    cyc();
    drive(1'b1, I_ADD, 32'h504, 1'b0, 1'b0);
    checks++;
    if ({out_valid, out_illegal, out_reg_we, out_mem_re, out_mem_we, out_branch, out_jump} !==
        7'b1100000) begin
      errors++;
      $display("FAIL zero_instr got v=%b ill=%b we=%b re=%b mw=%b br=%b jp=%b exp 1100000",
               out_valid, out_illegal, out_reg_we, out_mem_re, out_mem_we, out_branch, out_jump);
    end
    cyc();
    checks++;
    if (out_valid !== 1'b1 || observe() !== model(32'h0, 32'h500)) begin
      errors++; $display("FAIL zero_stall got v=%b %h", out_valid, observe());
    end
    rst = 1'b1;
    cyc();
    checks++;
    if ({out_valid, observe()} !== '0) begin
      errors++; $display("FAIL stall_reset got v=%b %h exp all 0", out_valid, observe());
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_reset_rdy got %b exp 1", in_ready); end
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    cyc();
  endtask

  task automatic test_decode_random();
    logic [31:0] ins, pc;
    for (int i = 0; i < 200; i++) begin
      ins = rand_instr();
      pc  = $urandom();
      drive(1'b1, ins, pc, 1'b0, 1'b1);
      cyc();
      checks++;
      if (out_valid !== 1'b1 || observe() !== model(ins, pc)) begin
        errors++;
        $display("FAIL decode[%0d] ins=%h got v=%b %h exp %h", i, ins, out_valid, observe(),
                 model(ins, pc));
      end
    end
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    cyc();
  endtask

  // Random valid/ready/flush traffic; the queue holds what execute should see next.
  task automatic test_back_to_back();
    bun_t        q[$];
    logic [31:0] ins, pc;
    logic        v, f, ordy, exp_rdy;
    for (int i = 0; i < 400; i++) begin
      ins  = rand_instr();
      pc   = $urandom();
      v    = ($urandom_range(0, 9) < 7);
      f    = ($urandom_range(0, 99) < 8);
      ordy = ($urandom_range(0, 9) < 6);
      drive(v, ins, pc, f, ordy);
      #1;
      exp_rdy = (q.size() == 0) || ordy;
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++; $display("FAIL b2b_in_ready[%0d] got %b exp %b", i, in_ready, exp_rdy);
      end
      checks++;
      if (out_valid !== (q.size() != 0)) begin
        errors++; $display("FAIL b2b_valid[%0d] got %b exp %b", i, out_valid, q.size() != 0);
      end
      if (q.size() != 0 && ordy) begin
        checks++;
        if (observe() !== q[0]) begin
          errors++; $display("FAIL b2b_data[%0d] got %h exp %h", i, observe(), q[0]);
        end
      end
      if (f) q.delete();
      else begin
        if (ordy && q.size() != 0) void'(q.pop_front());
        if (v && exp_rdy) q.push_back(model(ins, pc));
      end
      cyc();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    cyc();
  endtask

  initial begin
    test_reset();
    test_add();
    test_srai();
    test_store();
    test_back_pressure();
    test_flush();
    test_illegal_and_reset();
    test_decode_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
